// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath and its output quantizer.
package fir_pkg;

    // Raw FIR sample width and the accumulator width the filter produces.
    localparam int FIR_IN_WIDTH  = 16;
    localparam int FIR_OUT_WIDTH = 48;

    // Quantizer defaults: output sample width and number of LSBs dropped.
    localparam int Q_OUT_WIDTH   = 16;
    localparam int Q_SHIFT       = 30;

    // Nominal clocks between FIR output strobes.
    localparam int SAMPLE_PERIOD = 6;

    // Saturation counter width and the value it sticks at.
    localparam int              SAT_CNT_WIDTH = 16;
    localparam logic [15:0]     SAT_CNT_MAX   = 16'hFFFF;

    // Default depth of the quantizer output FIFO.
    localparam int Q_FIFO_DEPTH  = 4;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// The head entry is presented combinationally on o_data whenever o_valid is
// high; o_data reads 0 while the FIFO is empty. Pointers carry one extra bit
// so that full and empty can be told apart when the indices match.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_drop
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    // Same pointer value means empty; same index with opposite wrap bit means full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);

    // A pop on an empty FIFO is ignored, so push+pop while empty is a plain push.
    assign w_pop   = i_pop && !w_empty;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[IDX_W-1:0]];

    // Pointer update; both wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/fir_out_quantizer.sv
// FIR output quantizer: rounds a wide two's-complement accumulator sample
// to OUT_WIDTH bits (round half toward +inf), saturates, counts saturations
// and buffers results in a small FWFT FIFO with a sticky overflow flag.
//
// Pipeline: input capture -> stage 1 (add half LSB) -> stage 2 (shift and
// clamp) -> FIFO write. A strobe captured on edge N is visible at the FIFO
// head after edge N+3 when the FIFO was empty. The pipeline never stalls.
//
// Output handshake: out/out_valid present the FIFO head; an entry is
// consumed on a rising edge where out_valid and out_ready are both high.
// out_valid never depends on out_ready, and out is stable until consumed.
module fir_out_quantizer
    import fir_pkg::*;
#(
    parameter int IN_WIDTH  = FIR_OUT_WIDTH,
    parameter int OUT_WIDTH = Q_OUT_WIDTH,
    parameter int SHIFT     = Q_SHIFT,
    parameter int DEPTH     = Q_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [IN_WIDTH-1:0]      in,
    input  logic                     in_valid,
    output logic [OUT_WIDTH-1:0]     out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SAT_CNT_WIDTH-1:0] sat_cnt,
    output logic                     ovf
);

    // Half of one output LSB, in the widened stage-1 format.
    localparam logic [IN_WIDTH:0] RND_HALF = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam int                HI_W     = IN_WIDTH - OUT_WIDTH + 2;

    logic                        r_rst_sync;
    logic                        w_rst;

    logic [IN_WIDTH-1:0]         r_in;
    logic                        r_in_valid;

    logic [IN_WIDTH:0]           w_s1_sum;
    logic signed [IN_WIDTH:0]    r_s1_sum;
    logic                        r_s1_valid;

    logic signed [IN_WIDTH:0]    w_shift;
    logic [HI_W-1:0]             w_hi;
    logic                        w_fits;
    logic [OUT_WIDTH-1:0]        w_clamped;

    logic [OUT_WIDTH-1:0]        r_s2_data;
    logic                        r_s2_valid;
    logic                        r_s2_sat;

    logic                        w_drop;
    logic [SAT_CNT_WIDTH-1:0]    r_sat_cnt;
    logic                        r_ovf;

    // Reset assertion is immediate; release is retimed to the clock so that
    // every flop leaves reset on the same edge (first strobe taken on the
    // second edge after RST falls).
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_rst_sync <= 1'b1;
        end else begin
            r_rst_sync <= 1'b0;
        end
    end

    assign w_rst = r_rst_sync;

    // Input capture keeps the wide rounding adder off the upstream path.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_in       <= '0;
            r_in_valid <= 1'b0;
        end else begin
            r_in       <= in;
            r_in_valid <= in_valid;
        end
    end

    // One extra sign bit so adding the half LSB to the most positive input
    // cannot wrap.
    assign w_s1_sum = {r_in[IN_WIDTH-1], r_in} + RND_HALF;

    // Stage 1: register the rounded (not yet shifted) sum.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_s1_sum   <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_sum   <= w_s1_sum;
            r_s1_valid <= r_in_valid;
        end
    end

    // Arithmetic shift floors toward -inf, which together with the added
    // half LSB gives round-half-up.
    assign w_shift = r_s1_sum >>> SHIFT;

    // The value fits OUT_WIDTH bits exactly when every bit from the output
    // sign bit upward is a copy of that sign bit.
    assign w_hi      = w_shift[IN_WIDTH:OUT_WIDTH-1];
    assign w_fits    = (&w_hi) | ~(|w_hi);
    assign w_clamped = w_fits ? w_shift[OUT_WIDTH-1:0]
                              : {w_shift[IN_WIDTH], {(OUT_WIDTH-1){~w_shift[IN_WIDTH]}}};

    // Stage 2: register the clamped sample and whether clamping happened.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_s2_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sat   <= 1'b0;
        end else begin
            r_s2_data  <= w_clamped;
            r_s2_valid <= r_s1_valid;
            r_s2_sat   <= r_s1_valid && !w_fits;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (w_rst),
        .i_push  (r_s2_valid),
        .i_data  (r_s2_data),
        .i_pop   (out_ready),
        .o_data  (out),
        .o_valid (out_valid),
        .o_drop  (w_drop)
    );

    // Saturation counter: counts every clamped sample, dropped or not, and
    // sticks at its maximum.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_sat_cnt <= '0;
        end else if (r_s2_valid && r_s2_sat && (r_sat_cnt != SAT_CNT_MAX)) begin
            r_sat_cnt <= r_sat_cnt + SAT_CNT_WIDTH'(1);
        end
    end

    // Overflow flag: sticky once any sample is lost to a full FIFO.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign sat_cnt = r_sat_cnt;
    assign ovf     = r_ovf;

endmodule

// File: doc/fir_out_quantizer.md
FIR_OUT_QUANTIZER -- requirements
Module: fir_out_quantizer

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 48, meaning the width of the two's-complement FIR accumulator sample.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 16, meaning the width of the quantized output sample.
REQ-003 The block SHALL have parameter SHIFT, default 30, meaning the number of LSBs discarded (SHIFT >= 1).
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning the output FIFO depth (power of two, >= 2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-006 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port in, input, IN_WIDTH bits: signed FIR output sample.
REQ-008 The block SHALL have port in_valid, input, 1 bit: one-cycle strobe marking `in` as a new sample.
REQ-009 The block SHALL have port out, output, OUT_WIDTH bits: signed quantized sample at the FIFO head.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the FIFO is non-empty and `out` is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts `out` when out_valid and out_ready are both high.
REQ-012 The block SHALL have port sat_cnt, output, 16 bits: count of saturated samples, sticking at 0xFFFF.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky flag, set when a sample is dropped because the FIFO is full.

Function
REQ-014 Stage 1 SHALL register in + 2^(SHIFT-1), computed as an (IN_WIDTH+1)-bit signed sum (round half toward +inf), along with a valid bit.
REQ-015 Stage 2 SHALL arithmetic-shift the stage-1 sum right by SHIFT.
REQ-016 Stage 2 SHALL clamp the shifted value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and register it with a valid bit and a sat bit.
REQ-017 A stage-2 valid result SHALL be written to the FIFO on the following edge unless the FIFO is full.
REQ-018 If the FIFO is full, the stage-2 result SHALL be discarded and ovf SHALL be set.
REQ-019 Latency: in_valid sampled at edge N SHALL give out_valid=1 with the quantized value after edge N+3, provided the FIFO was empty.
REQ-020 The FIFO SHALL be first-word-fall-through: `out` SHALL always show the head entry while out_valid=1.
REQ-021 Pop SHALL occur only when out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-022 A simultaneous push and pop while full SHALL succeed: the pop frees the slot, nothing is dropped, and ovf is unchanged.
REQ-023 A simultaneous push and pop while empty SHALL push only; the pushed data becomes visible the following cycle.
REQ-024 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty SHALL be derived from the pointer MSB and index comparison.
REQ-025 sat_cnt SHALL increment by 1 for each stage-2 saturated sample, whether or not that sample is dropped.
REQ-026 sat_cnt SHALL hold at 0xFFFF once it reaches that value.
REQ-027 in_valid SHALL be accepted on every cycle; the pipeline never stalls, and back-to-back strobes are legal.

Reset
REQ-028 While RST=1, the pipeline valids, FIFO pointers, sat_cnt and ovf SHALL be 0, so out_valid=0; out SHALL read 0.
REQ-029 Reset asserted mid-operation SHALL immediately discard all in-flight and buffered samples.
REQ-030 RST deassertion SHALL be synchronized internally (async assert, sync release).
REQ-031 The first in_valid SHALL be accepted on the second edge after RST falls.

Structure
REQ-032 A shared package fir_pkg SHALL hold FIR_IN_WIDTH=16, FIR_OUT_WIDTH=48, Q_OUT_WIDTH=16, Q_SHIFT=30 and SAMPLE_PERIOD=6.
REQ-033 The FIFO SHALL be one sub-module, sync_fifo_fwft, parameterized by WIDTH and DEPTH.
REQ-034 Rounding, saturation and counters SHALL stay in the top module.

Verification
REQ-035 in=0x0000_4000_0000 with in_valid -> out=0x0001 three cycles later; sat_cnt=0.
REQ-036 in=0x0000_2000_0000 -> out=0x0001 (half rounds up); in=0x0000_1FFF_FFFF -> 0x0000; in=0xFFFF_E000_0000 -> 0x0000.
REQ-037 in=0x7FFF_FFFF_FFFF -> out=0x7FFF and sat_cnt=1; in=0x8000_0000_0000 -> out=0x8000 and sat_cnt=2.
REQ-038 out_ready=0, six back-to-back strobes with values 1..6 << 30 -> FIFO holds 1..4; ovf=1; then out_ready=1 -> reads 1,2,3,4, after which out_valid=0.
REQ-039 FIFO full, push and pop in the same cycle -> no drop; ovf stays 0; ordering is preserved.
REQ-040 RST pulsed with 3 entries buffered and 2 in flight -> out_valid=0 next cycle; sat_cnt=0; ovf=0.
REQ-041 One strobe every SAMPLE_PERIOD=6 cycles with out_ready=1, over 150000 samples -> outputs match the golden file exactly; ovf=0.
